shr_load_ctrl: RTL and testbench
================================

SHR_LOAD_CTRL -- requirements
Module: shr_load_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning shift-register length in bits (legal range 2..1024).
REQ-002 SHALL have parameter AW, default $clog2(WIDTH), meaning read-address width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_valid  input  1  load-vector valid.
REQ-006 SHALL have port s_data  input  WIDTH  vector to load; bit i lands at register position i.
REQ-007 SHALL have port s_ready  output  1  load vector accepted when s_valid&s_ready.
REQ-008 SHALL have port rd_valid  input  1  bit-read request.
REQ-009 SHALL have port rd_addr  input  AW  bit position to read.
REQ-010 SHALL have port rd_ready  output  1  read accepted when rd_valid&rd_ready.
REQ-011 SHALL have port rd_dvalid  output  1  rd_data valid, one-cycle pulse.
REQ-012 SHALL have port rd_data  output  1  read bit.
REQ-013 SHALL have port loaded  output  1  register holds a complete vector.
REQ-014 SHALL have port busy  output  1  shift sequence in progress.

Function
REQ-015 SHALL implement states IDLE, LOAD, READY.
REQ-016 SHALL, in IDLE, drive s_ready=1, rd_ready=0, loaded=0, busy=0.
REQ-017 SHALL, on accepted load in cycle T, capture s_data into a hold register, clear shift counter, enter LOAD.
REQ-018 SHALL, in LOAD, assert sh_en every cycle with din=hold[WIDTH-1-cnt], cnt incrementing 0..WIDTH-1, MSB shifted first.
REQ-019 SHALL complete exactly WIDTH shifts in cycles T+1..T+WIDTH, then enter READY with loaded=1 from cycle T+WIDTH+1.
REQ-020 SHALL, in LOAD, drive s_ready=0, rd_ready=0, loaded=0, busy=1; s_valid/rd_valid ignored.
REQ-021 SHALL, in READY, drive s_ready=1, rd_ready=1, busy=0, sh_en=0 (contents held indefinitely).
REQ-022 SHALL, on accepted read in cycle R, register the addressed bit and assert rd_dvalid=1 with rd_data in cycle R+1 only.
REQ-023 SHALL return rd_data=0 (rd_dvalid still 1) for rd_addr>=WIDTH.
REQ-024 SHALL, on simultaneous accepted load and read in READY, service the read from the old contents and start the new load (LOAD from next cycle).
REQ-025 SHALL, on a new load from READY, deassert loaded the following cycle until the new load completes.
REQ-026 SHALL hold rd_data stable between reads; rd_dvalid=0 when no read accepted previous cycle.

Reset
REQ-027 SHALL, on rstn low, immediately force state IDLE, cnt=0, hold=0, loaded=0, busy=0, rd_dvalid=0, rd_data=0, sh_en=0.
REQ-028 SHALL treat reset mid-LOAD as abandoning the load; partial register contents are don't-care and loaded stays 0 until a full load completes.
REQ-029 SHALL not reset the shift-register storage itself (kept LUT-mappable).

Structure
REQ-030 SHALL instantiate exactly one lut_shr (WIDTH passed through) as storage; its q_sel drives read data, q_msb unused.
REQ-031 SHALL place the state encoding (IDLE=0, LOAD=1, READY=2) in a shared package/include with the lut_shr constants.
REQ-032 SHALL size cnt as $clog2(WIDTH)+1 bits so terminal count WIDTH-1 is unambiguous.

Verification (WIDTH=8)
REQ-033 SHALL check: load s_data=8'hA5 at T -> busy 1 for T+1..T+8, loaded=1 at T+9, reads addr 0..7 return 1,0,1,0,0,1,0,1.
REQ-034 SHALL check: rd_valid during LOAD and in IDLE -> rd_ready=0, no rd_dvalid pulse.
REQ-035 SHALL check: in READY with 8'hA5, same-cycle load 8'h3C and read addr 7 -> rd_data=1 next cycle, later addr 7 reads 0, addr 2 reads 1.
REQ-036 SHALL check: rstn low at shift 4 of load 8'hFF -> outputs reset immediately; subsequent load 8'h01 gives addr0=1, addr1..7=0.
REQ-037 SHALL check: WIDTH=6 build, rd_addr=7 -> rd_dvalid=1, rd_data=0.
REQ-038 SHALL check: back-to-back reads addr 0,1,2 in consecutive cycles -> three consecutive rd_dvalid pulses with matching data.

Source files
------------

// File: rtl/shr_load_ctrl_pkg.sv
// Shared definitions for the shift-register load controller and its storage element.
package shr_load_ctrl_pkg;

  // Default storage length shared by the controller and lut_shr.
  localparam int unsigned ShrDefaultWidth = 64;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StReady = 2'd2
  } state_e;

endpackage

// File: rtl/lut_shr.sv
// Serial-in shift register with a random-access bit tap; no reset so it maps onto LUT shifters.
module lut_shr
  import shr_load_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = ShrDefaultWidth,
  parameter int unsigned AW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          sh_en,
  input  logic          din,
  input  logic [AW-1:0] sel,
  output logic          q_sel,
  output logic          q_msb
);

  localparam logic [AW:0] SelLimit = (AW + 1)'(WIDTH);

  logic [WIDTH-1:0] sr_q;

  // New bits enter at position 0 and migrate upward.
  always_ff @(posedge clk) begin
    if (sh_en) begin
      sr_q <= {sr_q[WIDTH-2:0], din};
    end
  end

  always_comb begin
    q_sel = 1'b0;
    if ({1'b0, sel} < SelLimit) begin
      q_sel = sr_q[sel];
    end
  end

  assign q_msb = sr_q[WIDTH-1];

endmodule

// File: rtl/shr_load_ctrl.sv
// Loads a parallel vector into a LUT shift register MSB-first, then serves single-bit reads.
module shr_load_ctrl
  import shr_load_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = ShrDefaultWidth,
  parameter int unsigned AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  input  logic             rd_valid,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_ready,
  output logic             rd_dvalid,
  output logic             rd_data,
  output logic             loaded,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             rd_dvalid_q, rd_data_q;
  logic             s_fire, rd_fire, sh_en, din, q_sel;
  logic [CW-1:0]    sh_idx;
  logic             unused_q_msb, unused_idx_msb;

  assign s_fire   = s_valid & s_ready;
  assign rd_fire  = rd_valid & rd_ready;
  assign s_ready  = (state_q != StLoad);
  assign rd_ready = (state_q == StReady);
  assign loaded   = (state_q == StReady);
  assign busy     = (state_q == StLoad);
  assign sh_en    = (state_q == StLoad);

  // Top bit of the index is always zero once cnt is in range.
  assign sh_idx         = CW'(WIDTH - 1) - cnt_q;
  assign unused_idx_msb = sh_idx[CW-1];
  assign din            = hold_q[sh_idx[CW-2:0]];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle, StReady: begin
        if (s_fire) begin
          hold_d  = s_data;
          cnt_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = StReady;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hold_q      <= '0;
      rd_dvalid_q <= 1'b0;
      rd_data_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      rd_dvalid_q <= rd_fire;
      if (rd_fire) begin
        rd_data_q <= q_sel;
      end
    end
  end

  assign rd_dvalid = rd_dvalid_q;
  assign rd_data   = rd_data_q;

  lut_shr #(
    .WIDTH(WIDTH),
    .AW   (AW)
  ) u_lut_shr (
    .clk  (clk),
    .sh_en(sh_en),
    .din  (din),
    .sel  (rd_addr),
    .q_sel(q_sel),
    .q_msb(unused_q_msb)
  );

endmodule

// File: tb/tb_shr_load_ctrl.sv
// Randomized and directed bench for shr_load_ctrl against a vector-level reference model.
module tb_shr_load_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned A  = 3;
  localparam int unsigned W6 = 6;
  localparam int unsigned A6 = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic         s_valid = 1'b0, rd_valid = 1'b0;
  logic [W-1:0] s_data = '0;
  logic [A-1:0] rd_addr = '0;
  logic         s_ready, rd_ready, rd_dvalid, rd_data, loaded, busy;

  logic          s_valid6 = 1'b0, rd_valid6 = 1'b0;
  logic [W6-1:0] s_data6 = '0;
  logic [A6-1:0] rd_addr6 = '0;
  logic          s_ready6, rd_ready6, rd_dvalid6, rd_data6, loaded6, busy6;

  shr_load_ctrl #(.WIDTH(W), .AW(A)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_dvalid(rd_dvalid),
    .rd_data(rd_data), .loaded(loaded), .busy(busy)
  );

  shr_load_ctrl #(.WIDTH(W6), .AW(A6)) dut6 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid6), .s_data(s_data6), .s_ready(s_ready6),
    .rd_valid(rd_valid6), .rd_addr(rd_addr6), .rd_ready(rd_ready6), .rd_dvalid(rd_dvalid6),
    .rd_data(rd_data6), .loaded(loaded6), .busy(busy6)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a vector is either complete (m_have) or in flight for m_busy more cycles.
  logic [W-1:0] m_vec  = '0;
  logic [W-1:0] m_pend = '0;
  bit           m_have = 1'b0;
  int           m_busy = 0;
  bit           m_dv   = 1'b0;
  logic         m_rd   = 1'b0;

  task automatic check_outputs(input string where);
    check_eq({where, ":s_ready"}, 32'(s_ready), 32'(m_busy == 0));
    check_eq({where, ":rd_ready"}, 32'(rd_ready), 32'((m_busy == 0) && m_have));
    check_eq({where, ":loaded"}, 32'(loaded), 32'((m_busy == 0) && m_have));
    check_eq({where, ":busy"}, 32'(busy), 32'(m_busy != 0));
    check_eq({where, ":rd_dvalid"}, 32'(rd_dvalid), 32'(m_dv));
    check_eq({where, ":rd_data"}, 32'(rd_data), 32'(m_rd));
  endtask

  task automatic model_reset();
    m_have = 1'b0;
    m_busy = 0;
    m_dv   = 1'b0;
    m_rd   = 1'b0;
  endtask

  task automatic cycle(input logic sv, input logic [W-1:0] sd, input logic rv,
                       input logic [A-1:0] ra, input string where);
    s_valid  = sv;
    s_data   = sd;
    rd_valid = rv;
    rd_addr  = ra;
    #1;
    check_outputs(where);
    if (m_busy > 0) begin
      m_dv = 1'b0;
      m_busy--;
      if (m_busy == 0) begin
        m_vec  = m_pend;
        m_have = 1'b1;
      end
    end else begin
      m_dv = rv && m_have;
      if (m_dv) m_rd = (int'(ra) < W) ? m_vec[ra] : 1'b0;
      if (sv) begin
        m_pend = sd;
        m_busy = W;
        m_have = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input string where);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, where);
  endtask

  task automatic read_all(input string where);
    for (int a = 0; a < W; a++) cycle(1'b0, '0, 1'b1, A'(a), where);
    idle(1, where);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  logic [W6-1:0] vec6;
  bit            seen6;

  initial begin
    #2;
    check_outputs("por");
    @(posedge clk);
    #1;
    rstn = 1'b1;

    cycle(1'b0, '0, 1'b1, 3'd3, "idle_rd");
    idle(1, "idle_after_rd");

    cycle(1'b1, 8'hA5, 1'b0, '0, "load_a5");
    for (int i = 0; i < W; i++) cycle(1'b1, 8'h00, 1'b1, 3'd5, "in_load");
    read_all("rd_a5");
    check_eq("a5_last_bit", 32'(rd_data), 32'(1));

    cycle(1'b1, 8'h3C, 1'b1, 3'd7, "ld_rd_same");
    idle(W, "load_3c");
    cycle(1'b0, '0, 1'b1, 3'd7, "rd_3c_a7");
    cycle(1'b0, '0, 1'b1, 3'd2, "rd_3c_a2");
    idle(1, "rd_3c_done");

    cycle(1'b1, 8'hFF, 1'b0, '0, "load_ff");
    idle(4, "shift_ff");
    do_reset();
    cycle(1'b1, 8'h01, 1'b0, '0, "load_01");
    idle(W, "shift_01");
    read_all("rd_01");

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) == 0), W'($urandom), 1'($urandom), A'($urandom), "rand");
    end
    idle(W + 1, "drain");

    vec6     = 6'b101101;
    s_valid6 = 1'b1;
    s_data6  = vec6;
    @(posedge clk);
    #1;
    s_valid6 = 1'b0;
    seen6    = 1'b0;
    for (int k = 0; k < 20 && !seen6; k++) begin
      if (loaded6) seen6 = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check_eq("w6_loaded", 32'(seen6), 32'(1));
    for (int a = 0; a < 8; a++) begin
      rd_valid6 = 1'b1;
      rd_addr6  = A6'(a);
      #1;
      check_eq("w6_rd_ready", 32'(rd_ready6), 32'(1));
      @(posedge clk);
      #1;
      rd_valid6 = 1'b0;
      check_eq("w6_rd_dvalid", 32'(rd_dvalid6), 32'(1));
      check_eq("w6_rd_data", 32'(rd_data6), 32'((a < int'(W6)) ? vec6[a] : 1'b0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
